hamming_bit_serializer: RTL and testbench



---
 rtl/hamming_pkg.sv | 24 ++
 rtl/hamming_word_buf.sv | 31 +++
 rtl/hamming_bit_serializer.sv | 143 ++++++++++++++
 tb/tb_hamming_bit_serializer.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming serializer / accumulator pair.
// Optional macro HAMMING_SER_PRELOAD_EN is consumed by hamming_bit_serializer.
package hamming_pkg;

    localparam int HAMMING_N = 16;

    // Bit index counter width for an n-bit word (n >= 2).
    function automatic int calc_cnt_w(input int n);
        return $clog2(n);
    endfunction

    // Width of the downstream accumulator count, which must hold the value n.
    function automatic int calc_acc_w(input int n);
        return $clog2(n) + 1;
    endfunction

    localparam int HAMMING_ACC_W = $clog2(HAMMING_N) + 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/hamming_word_buf.sv
// Single-entry holding register with a full flag. Used by the serializer to
// park the next word pair while the current one is still shifting out.
module hamming_word_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic         rd_en,
    input  logic [W-1:0] wr_data,
    output logic         full,
    output logic [W-1:0] rd_data
);

    // Capture on write, release on read; the owner never does both at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full    <= 1'b0;
            // NOTE: this is a single flop word, so resetting it is cheap and keeps
            // rd_data defined; a real RAM array would be left unreset and only
            // the full flag would qualify its contents.
            rd_data <= '0;
        end else if (wr_en) begin
            full    <= 1'b1;
            rd_data <= wr_data;
        end else if (rd_en) begin
            full    <= 1'b0;
        end
    end

endmodule

// File: rtl/hamming_bit_serializer.sv
// Serializes a (garbler, evaluator) word pair LSB first into the sequential
// Hamming accumulator, flagging first/last bit and pulsing done once the
// accumulator's count is final.
// Define HAMMING_SER_PRELOAD_EN to add a holding register for gap-free
// back-to-back pairs.
module hamming_bit_serializer
    import hamming_pkg::*;
#(
    parameter  int N     = HAMMING_N,
    localparam int CNT_W = calc_cnt_w(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] g_word,
    input  logic [N-1:0] e_word,
    output logic         g_bit,
    output logic         e_bit,
    output logic         bit_valid,
    output logic         first,
    output logic         last,
    output logic         done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t             state;
    state_t             state_next;
    logic [N-1:0]       g_sr;
    logic [N-1:0]       e_sr;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               at_last;
    logic               load_sr;
    logic [N-1:0]       load_g;
    logic [N-1:0]       load_e;

    assign accept  = in_valid & in_ready;
    assign at_last = (state == S_SHIFT) && (cnt == CNT_LAST);

`ifdef HAMMING_SER_PRELOAD_EN
    logic           hold_full;
    logic           hold_wr;
    logic           hold_rd;
    logic [2*N-1:0] hold_data;

    // A pair arriving mid-shift is parked; one arriving on the last bit with
    // the hold empty bypasses straight into the shift registers.
    assign in_ready = !hold_full;
    assign hold_wr  = accept && (state == S_SHIFT) && !at_last;
    assign hold_rd  = at_last && hold_full;

    hamming_word_buf #(
        .W (2 * N)
    ) u_word_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (hold_wr),
        .rd_en   (hold_rd),
        .wr_data ({g_word, e_word}),
        .full    (hold_full),
        .rd_data (hold_data)
    );
`else
    assign in_ready = (state == S_IDLE);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop
            // samples pre-edge values regardless of block evaluation order.
            state <= state_next;
        end
    end

    // Next-state and shift-register load selection.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next = state;
        load_sr    = 1'b0;
        load_g     = g_word;
        load_e     = e_word;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    load_sr    = 1'b1;
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (at_last) begin
                    state_next = S_IDLE;
`ifdef HAMMING_SER_PRELOAD_EN
                    if (hold_full) begin
                        load_sr    = 1'b1;
                        load_g     = hold_data[2*N-1:N];
                        load_e     = hold_data[N-1:0];
                        state_next = S_SHIFT;
                    end else if (accept) begin
                        load_sr    = 1'b1;
                        state_next = S_SHIFT;
                    end
`endif
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Shift registers, bit counter and the done pulse registered from last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_sr <= '0;
            e_sr <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= at_last;
            if (load_sr) begin
                g_sr <= load_g;
                e_sr <= load_e;
                cnt  <= '0;
            end else if (state == S_SHIFT) begin
                g_sr <= g_sr >> 1;
                e_sr <= e_sr >> 1;
                cnt  <= at_last ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    // Serial outputs come only from registered state; idle cycles read as 0.
    assign bit_valid = (state == S_SHIFT);
    assign g_bit     = bit_valid & g_sr[0];
    assign e_bit     = bit_valid & e_sr[0];
    assign first     = bit_valid && (cnt == '0);
    assign last      = at_last;

endmodule

// File: tb/tb_hamming_bit_serializer.sv
// Directed bench for hamming_bit_serializer at N=16 and N=5, with a small
// accumulator model counting g_bit ^ e_bit per pair.
module tb_hamming_bit_serializer;

`ifdef HAMMING_SER_PRELOAD_EN
    localparam int PERIOD16 = 16;
`else
    localparam int PERIOD16 = 17;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic        in_valid16 = 1'b0, in_ready16;
    logic [15:0] g_word16 = '0, e_word16 = '0;
    logic        g_bit16, e_bit16, bit_valid16, first16, last16, done16;

    logic        in_valid5 = 1'b0, in_ready5;
    logic [4:0]  g_word5 = '0, e_word5 = '0;
    logic        g_bit5, e_bit5, bit_valid5, first5, last5, done5;

    hamming_bit_serializer #(.N(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .g_word(g_word16), .e_word(e_word16), .g_bit(g_bit16), .e_bit(e_bit16),
        .bit_valid(bit_valid16), .first(first16), .last(last16), .done(done16)
    );

    hamming_bit_serializer #(.N(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5),
        .g_word(g_word5), .e_word(e_word5), .g_bit(g_bit5), .e_bit(e_bit5),
        .bit_valid(bit_valid5), .first(first5), .last(last5), .done(done5)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation state; cycle labels are cyc+1 sampled on the falling edge.
    int          hd16 = 0, idx16 = 0, nbits16 = 0, last_t16 = 0, done_t16 = 0;
    logic        ready_at_done16 = 1'b0;
    logic [15:0] cap_g16 = '0, cap_e16 = '0;
    int          firsts16[$];
    int          dones16[$];

    int          hd5 = 0, idx5 = 0, last_t5 = 0, done_t5 = 0;
    logic [4:0]  cap_g5 = '0, cap_e5 = '0;
    int          firsts5[$];
    int          dones5[$];

    // Accumulator model and event recorder for the N=16 instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (done16) begin
                done_t16 = cyc + 1;
                ready_at_done16 = in_ready16;
                dones16.push_back(hd16);
            end
            if (bit_valid16) begin
                if (first16) begin
                    hd16 = 0; idx16 = 0; cap_g16 = '0; cap_e16 = '0;
                    firsts16.push_back(cyc + 1);
                end
                hd16 += int'(g_bit16 ^ e_bit16);
                if (idx16 < 16) begin
                    cap_g16[idx16] = g_bit16;
                    cap_e16[idx16] = e_bit16;
                end
                idx16++;
                nbits16++;
            end
            if (last16) last_t16 = cyc + 1;
        end
    end

    // Accumulator model and event recorder for the N=5 instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (done5) begin
                done_t5 = cyc + 1;
                dones5.push_back(hd5);
            end
            if (bit_valid5) begin
                if (first5) begin
                    hd5 = 0; idx5 = 0; cap_g5 = '0; cap_e5 = '0;
                    firsts5.push_back(cyc + 1);
                end
                hd5 += int'(g_bit5 ^ e_bit5);
                if (idx5 < 5) begin
                    cap_g5[idx5] = g_bit5;
                    cap_e5[idx5] = e_bit5;
                end
                idx5++;
            end
            if (last5) last_t5 = cyc + 1;
        end
    end

    task automatic send16(input logic [15:0] g, input logic [15:0] e, output int t);
        @(posedge clk); #1;
        in_valid16 = 1'b1; g_word16 = g; e_word16 = e;
        t = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready16) begin t = cyc + 1; break; end
        end
        @(posedge clk); #1;
        in_valid16 = 1'b0; g_word16 = ~g; e_word16 = ~e;
        if (t < 0) begin
            total++; bad++;
            $display("FAIL send16_timeout: in_ready never rose");
        end
    endtask

    task automatic send5(input logic [4:0] g, input logic [4:0] e, output int t);
        @(posedge clk); #1;
        in_valid5 = 1'b1; g_word5 = g; e_word5 = e;
        t = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready5) begin t = cyc + 1; break; end
        end
        @(posedge clk); #1;
        in_valid5 = 1'b0; g_word5 = ~g; e_word5 = ~e;
        if (t < 0) begin
            total++; bad++;
            $display("FAIL send5_timeout: in_ready never rose");
        end
    endtask

    task automatic wait_done16(input int n);
        int i;
        for (i = 0; i < 200 && dones16.size() < n; i++) @(negedge clk);
        @(negedge clk);
        total++;
        if (dones16.size() < n) begin
            bad++;
            $display("FAIL wait_done16: dones=%0d required=%0d", dones16.size(), n);
        end
    endtask

    task automatic wait_done5(input int n);
        int i;
        for (i = 0; i < 100 && dones5.size() < n; i++) @(negedge clk);
        @(negedge clk);
        total++;
        if (dones5.size() < n) begin
            bad++;
            $display("FAIL wait_done5: dones=%0d required=%0d", dones5.size(), n);
        end
    endtask

    task automatic clear16();
        firsts16.delete(); dones16.delete(); nbits16 = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready16 !== 1'b1) begin
            bad++; $display("FAIL reset_ready16: got %b required 1", in_ready16);
        end
        total++;
        if ({g_bit16, e_bit16, bit_valid16, first16, last16, done16} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outs16: got %b required 000000",
                     {g_bit16, e_bit16, bit_valid16, first16, last16, done16});
        end
        total++;
        if ({in_ready5, bit_valid5, done5} !== 3'b100) begin
            bad++; $display("FAIL reset_outs5: got %b required 100", {in_ready5, bit_valid5, done5});
        end
    endtask

    task automatic test_single();
        int t;
        clear16();
        send16(16'hFFFF, 16'h0000, t);
        wait_done16(1);
        total++;
        if (firsts16.size() < 1 || firsts16[0] != t + 1) begin
            bad++; $display("FAIL single_first: accept=%0d first=%0d required %0d",
                            t, (firsts16.size() > 0) ? firsts16[0] : -1, t + 1);
        end
        total++;
        if (last_t16 != t + 16) begin
            bad++; $display("FAIL single_last: got %0d required %0d", last_t16, t + 16);
        end
        total++;
        if (done_t16 != t + 17) begin
            bad++; $display("FAIL single_done: got %0d required %0d", done_t16, t + 17);
        end
        total++;
        if (dones16.size() < 1 || dones16[0] != 16) begin
            bad++; $display("FAIL single_count: got %0d required 16",
                            (dones16.size() > 0) ? dones16[0] : -1);
        end
        total++;
        if (nbits16 != 16) begin
            bad++; $display("FAIL single_nbits: got %0d required 16", nbits16);
        end
        total++;
        if (ready_at_done16 !== 1'b1) begin
            bad++; $display("FAIL single_ready_at_done: got %b required 1", ready_at_done16);
        end
        total++;
        if (cap_g16 !== 16'hFFFF || cap_e16 !== 16'h0000) begin
            bad++; $display("FAIL single_bits: got g=%h e=%h required g=ffff e=0000", cap_g16, cap_e16);
        end
    endtask

    task automatic test_bit_order();
        int t;
        clear16();
        send16(16'h0001, 16'h8000, t);
        wait_done16(1);
        total++;
        if (cap_g16 !== 16'h0001 || cap_e16 !== 16'h8000) begin
            bad++; $display("FAIL order_bits: got g=%h e=%h required g=0001 e=8000", cap_g16, cap_e16);
        end
        total++;
        if (dones16.size() < 1 || dones16[0] != 2) begin
            bad++; $display("FAIL order_count: got %0d required 2",
                            (dones16.size() > 0) ? dones16[0] : -1);
        end
    endtask

    task automatic test_odd_width();
        int t;
        firsts5.delete(); dones5.delete();
        send5(5'b10110, 5'b00011, t);
        wait_done5(1);
        total++;
        if (last_t5 != t + 5 || done_t5 != t + 6) begin
            bad++; $display("FAIL odd_timing: last=%0d done=%0d required %0d %0d",
                            last_t5, done_t5, t + 5, t + 6);
        end
        total++;
        if (dones5.size() < 1 || dones5[0] != 3) begin
            bad++; $display("FAIL odd_count: got %0d required 3", (dones5.size() > 0) ? dones5[0] : -1);
        end
        total++;
        if (cap_g5 !== 5'b10110 || cap_e5 !== 5'b00011) begin
            bad++; $display("FAIL odd_bits: got g=%b e=%b required 10110 00011", cap_g5, cap_e5);
        end
        // Second pair proves the counter wrapped back to 0.
        send5(5'b11111, 5'b00000, t);
        wait_done5(2);
        total++;
        if (firsts5.size() < 2 || firsts5[1] != t + 1 || last_t5 != t + 5) begin
            bad++; $display("FAIL odd_wrap: first=%0d last=%0d required %0d %0d",
                            (firsts5.size() > 1) ? firsts5[1] : -1, last_t5, t + 1, t + 5);
        end
        total++;
        if (dones5.size() < 2 || dones5[1] != 5) begin
            bad++; $display("FAIL odd_count2: got %0d required 5", (dones5.size() > 1) ? dones5[1] : -1);
        end
    endtask

    task automatic test_back_to_back();
        int n_acc;
        clear16();
        @(posedge clk); #1;
        in_valid16 = 1'b1; g_word16 = 16'hA5A5; e_word16 = 16'h5A5A;
        n_acc = 0;
        for (int i = 0; i < 200 && n_acc < 3; i++) begin
            @(negedge clk);
            if (in_ready16) n_acc++;
        end
        @(posedge clk); #1;
        in_valid16 = 1'b0; g_word16 = '0; e_word16 = '0;
        wait_done16(3);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (dones16.size() <= k || dones16[k] != 16) begin
                bad++; $display("FAIL b2b_count%0d: got %0d required 16", k,
                                (dones16.size() > k) ? dones16[k] : -1);
            end
        end
        for (int k = 1; k < 3; k++) begin
            total++;
            if (firsts16.size() <= k || firsts16[k] - firsts16[k-1] != PERIOD16) begin
                bad++; $display("FAIL b2b_period%0d: got %0d required %0d", k,
                                (firsts16.size() > k) ? firsts16[k] - firsts16[k-1] : -1, PERIOD16);
            end
        end
        total++;
        if (nbits16 != 48 || firsts16.size() < 1 || last_t16 - firsts16[0] + 1 != 3 * PERIOD16 - (PERIOD16 - 16)) begin
            bad++; $display("FAIL b2b_window: bits=%0d span=%0d required 48 %0d", nbits16,
                            (firsts16.size() > 0) ? last_t16 - firsts16[0] + 1 : -1,
                            3 * PERIOD16 - (PERIOD16 - 16));
        end
    endtask

    task automatic test_last_cycle_arrival();
        int t1, t2;
        clear16();
        send16(16'h1234, 16'h0000, t1);
        // Next send drives in_valid during the last-bit cycle of the first pair.
        repeat (14) @(posedge clk);
        send16(16'h00F0, 16'h0F0F, t2);
        wait_done16(2);
        total++;
        if (t2 - t1 != PERIOD16) begin
            bad++; $display("FAIL arrive_accept: got %0d required %0d", t2 - t1, PERIOD16);
        end
        total++;
        if (firsts16.size() < 2 || firsts16[1] - firsts16[0] != PERIOD16) begin
            bad++; $display("FAIL arrive_first: got %0d required %0d",
                            (firsts16.size() > 1) ? firsts16[1] - firsts16[0] : -1, PERIOD16);
        end
        total++;
        if (cap_g16 !== 16'h00F0 || cap_e16 !== 16'h0F0F) begin
            bad++; $display("FAIL arrive_bits: got g=%h e=%h required 00f0 0f0f", cap_g16, cap_e16);
        end
        total++;
        if (dones16.size() < 2 || dones16[0] != 5 || dones16[1] != 12) begin
            bad++; $display("FAIL arrive_counts: got %0d %0d required 5 12",
                            (dones16.size() > 0) ? dones16[0] : -1, (dones16.size() > 1) ? dones16[1] : -1);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        clear16();
        send16(16'hFFFF, 16'h0000, t);
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (bit_valid16 !== 1'b1) begin
            bad++; $display("FAIL midrst_pre: bit_valid=%b required 1", bit_valid16);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({bit_valid16, first16, last16, done16, in_ready16} !== 5'b00001) begin
            bad++; $display("FAIL midrst_outs: got %b required 00001",
                            {bit_valid16, first16, last16, done16, in_ready16});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        total++;
        if (dones16.size() != 0) begin
            bad++; $display("FAIL midrst_done: got %0d dones required 0", dones16.size());
        end
        send16(16'h000F, 16'h0000, t);
        wait_done16(1);
        total++;
        if (dones16.size() < 1 || dones16[0] != 4) begin
            bad++; $display("FAIL midrst_recover: got %0d required 4",
                            (dones16.size() > 0) ? dones16[0] : -1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_bit_order();
        test_odd_width();
        test_back_to_back();
        test_last_cycle_arrival();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
